// File: rtl/led_mon_pkg.sv
// Shared definitions for the LED rotation monitor: FSM state encoding and
// direction constants used by the monitor and its bench.
package led_mon_pkg;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic DIR_DEC = 1'b0;
  localparam logic DIR_INC = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Sample-strobe generator: a free-running DIV_N-bit counter; tick is high
// for exactly the one clk cycle in which the counter holds all ones.
// The strobe is produced by a register that anticipates the all-ones value,
// so it is glitch-free and needs no output decode.
module led_tick_gen #(
  parameter int DIV_N = 25
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [DIV_N-1:0] CNT_ONE = DIV_N'(1'b1);
  localparam logic [DIV_N-1:0] CNT_PRE = {DIV_N{1'b1}} - CNT_ONE;

  logic [DIV_N-1:0] cnt_r;

  // Free-running divider; tick asserts while the counter sits at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
      tick  <= (cnt_r == CNT_PRE);
    end
  end

endmodule

// File: rtl/led_rotation_monitor.sv
// Receive-side checker for a rotating one-hot LED bus. On every divider
// tick the LED vector is sampled, the lit position encoded, and the step
// relative to the previous accepted position classified as hold, +1, -1
// (with wrap-around) or illegal. Illegal samples latch a sticky fault that
// only clr releases.
// Optional build macro LED_MON_LAP_COUNT_EN adds a saturating lap counter.
module led_rotation_monitor
  import led_mon_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int POS_W = 4,
  parameter int CNT_W = 8,
  parameter int DIV_N = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] led_in,
  output logic [POS_W-1:0] pos,
  output logic             pos_valid,
  output logic             dir,
  output logic             moving,
  output logic             err,
  output logic [CNT_W-1:0] step_cnt,
`ifdef LED_MON_LAP_COUNT_EN
  output logic [CNT_W-1:0] lap_cnt,
`endif
  output logic             tick
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] POS_ZERO = POS_W'(0);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [WIDTH-1:0] LED_ONE  = WIDTH'(1'b1);

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    is_onehot = (v != '0) && ((v & (v - LED_ONE)) == '0);
  endfunction

  // Index of the set bit; only meaningful for one-hot input.
  function automatic logic [POS_W-1:0] encode(input logic [WIDTH-1:0] v);
    logic [POS_W-1:0] r;
    r = POS_ZERO;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) r = POS_W'(i);
      else      r = r;
    end
    encode = r;
  endfunction

  // Counter increment that sticks at the maximum value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) sat_inc = v;
    else              sat_inc = v + CNT_ONE;
  endfunction

  logic             tick_s;
  logic             onehot_s;
  logic [POS_W-1:0] idx_s;
  logic [POS_W-1:0] pos_inc_s;
  logic [POS_W-1:0] pos_dec_s;
  logic             same_s;
  logic             inc_s;
  logic             dec_s;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [POS_W-1:0] pos_nxt_s;
  logic             pos_valid_nxt_s;
  logic             dir_nxt_s;
  logic             moving_nxt_s;
  logic             err_nxt_s;
  logic [CNT_W-1:0] step_nxt_s;
`ifdef LED_MON_LAP_COUNT_EN
  logic [CNT_W-1:0] lap_nxt_s;
`endif

  led_tick_gen #(
    .DIV_N (DIV_N)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  assign tick = tick_s;

  // Classify the sampled vector against the currently tracked position.
  always_comb begin
    onehot_s  = is_onehot(led_in);
    idx_s     = encode(led_in);
    pos_inc_s = (pos == POS_LAST) ? POS_ZERO : (pos + POS_ONE);
    pos_dec_s = (pos == POS_ZERO) ? POS_LAST : (pos - POS_ONE);
    same_s    = (idx_s == pos);
    inc_s     = (idx_s == pos_inc_s);
    dec_s     = (idx_s == pos_dec_s);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ACQ;
    else     state_r <= state_nxt_s;
  end

  // FSM next-state: clr wins over a coincident tick; FAULT ignores ticks.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = ACQ;
    end else if (tick_s) begin
      case (state_r)
        ACQ:     state_nxt_s = onehot_s ? TRACK : FAULT;
        TRACK:   state_nxt_s = (onehot_s && (same_s || inc_s || dec_s)) ? TRACK : FAULT;
        FAULT:   state_nxt_s = FAULT;
        default: state_nxt_s = FAULT;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM outputs: next values of the registered observation outputs.
  always_comb begin
    pos_nxt_s       = pos;
    pos_valid_nxt_s = pos_valid;
    dir_nxt_s       = dir;
    moving_nxt_s    = moving;
    err_nxt_s       = err;
    step_nxt_s      = step_cnt;
`ifdef LED_MON_LAP_COUNT_EN
    lap_nxt_s       = lap_cnt;
`endif
    if (clr) begin
      err_nxt_s       = 1'b0;
      pos_valid_nxt_s = 1'b0;
      moving_nxt_s    = 1'b0;
      step_nxt_s      = '0;
`ifdef LED_MON_LAP_COUNT_EN
      lap_nxt_s       = '0;
`endif
    end else if (tick_s) begin
      case (state_r)
        ACQ: begin
          if (onehot_s) begin
            pos_nxt_s       = idx_s;
            pos_valid_nxt_s = 1'b1;
            moving_nxt_s    = 1'b0;
          end else begin
            err_nxt_s       = 1'b1;
            pos_valid_nxt_s = 1'b0;
            moving_nxt_s    = 1'b0;
          end
        end
        TRACK: begin
          if (!onehot_s) begin
            err_nxt_s       = 1'b1;
            pos_valid_nxt_s = 1'b0;
            moving_nxt_s    = 1'b0;
          end else if (same_s) begin
            moving_nxt_s    = 1'b0;
          end else if (inc_s) begin
            pos_nxt_s       = idx_s;
            dir_nxt_s       = DIR_INC;
            moving_nxt_s    = 1'b1;
            step_nxt_s      = sat_inc(step_cnt);
`ifdef LED_MON_LAP_COUNT_EN
            if (pos == POS_LAST) lap_nxt_s = sat_inc(lap_cnt);
            else                 lap_nxt_s = lap_cnt;
`endif
          end else if (dec_s) begin
            pos_nxt_s       = idx_s;
            dir_nxt_s       = DIR_DEC;
            moving_nxt_s    = 1'b1;
            step_nxt_s      = sat_inc(step_cnt);
`ifdef LED_MON_LAP_COUNT_EN
            if (pos == POS_ZERO) lap_nxt_s = sat_inc(lap_cnt);
            else                 lap_nxt_s = lap_cnt;
`endif
          end else begin
            err_nxt_s       = 1'b1;
            pos_valid_nxt_s = 1'b0;
            moving_nxt_s    = 1'b0;
          end
        end
        FAULT: begin
          err_nxt_s       = 1'b1;
          pos_valid_nxt_s = 1'b0;
          moving_nxt_s    = 1'b0;
        end
        default: begin
          err_nxt_s       = 1'b1;
          pos_valid_nxt_s = 1'b0;
          moving_nxt_s    = 1'b0;
        end
      endcase
    end else begin
      err_nxt_s = err;
    end
  end

  // Observation output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos       <= '0;
      pos_valid <= 1'b0;
      dir       <= DIR_DEC;
      moving    <= 1'b0;
      err       <= 1'b0;
      step_cnt  <= '0;
    end else begin
      pos       <= pos_nxt_s;
      pos_valid <= pos_valid_nxt_s;
      dir       <= dir_nxt_s;
      moving    <= moving_nxt_s;
      err       <= err_nxt_s;
      step_cnt  <= step_nxt_s;
    end
  end

`ifdef LED_MON_LAP_COUNT_EN
  // Lap counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lap_cnt <= '0;
    else     lap_cnt <= lap_nxt_s;
  end
`endif

endmodule

// File: tb/tb_led_rotation_monitor.sv
// Self-checking bench for led_rotation_monitor (WIDTH=16, DIV_N=2).
// Each sample pushes its expected observation into a scoreboard queue; the
// entry is popped and compared once the DUT has taken that sample.
module tb_led_rotation_monitor;

  localparam int WIDTH = 16;
  localparam int POS_W = 4;
  localparam int CNT_W = 8;
  localparam int DIV_N = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] led_in = '0;
  logic [POS_W-1:0] pos;
  logic             pos_valid;
  logic             dir;
  logic             moving;
  logic             err;
  logic [CNT_W-1:0] step_cnt;
  logic             tick;
`ifdef LED_MON_LAP_COUNT_EN
  logic [CNT_W-1:0] lap_cnt;
`endif

  led_rotation_monitor #(
    .WIDTH (WIDTH),
    .POS_W (POS_W),
    .CNT_W (CNT_W),
    .DIV_N (DIV_N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .led_in    (led_in),
    .pos       (pos),
    .pos_valid (pos_valid),
    .dir       (dir),
    .moving    (moving),
    .err       (err),
    .step_cnt  (step_cnt),
`ifdef LED_MON_LAP_COUNT_EN
    .lap_cnt   (lap_cnt),
`endif
    .tick      (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pos;
    logic       valid;
    logic       dir;
    logic       mov;
    logic       err;
    logic [7:0] step;
    logic [7:0] lap;
  } snap_t;

  // kind: 0 = sample at a tick, 1 = sample at a tick with clr, 2 = bare clr pulse
  typedef struct packed {
    logic [15:0] led;
    logic [1:0]  kind;
  } stim_t;

  snap_t exp_q[$];
  stim_t stim_q[$];
  snap_t obs;
  int    total = 0;
  int    bad   = 0;

  function automatic snap_t mk(input int p, input int v, input int d, input int m,
                               input int e, input int s, input int l);
    snap_t r;
    r.pos   = 4'(p);
    r.valid = 1'(v);
    r.dir   = 1'(d);
    r.mov   = 1'(m);
    r.err   = 1'(e);
    r.step  = 8'(s);
`ifdef LED_MON_LAP_COUNT_EN
    r.lap   = 8'(l);
`else
    r.lap   = 8'(l) & 8'h00;
`endif
    return r;
  endfunction

  function automatic snap_t grab();
    snap_t r;
    r.pos   = pos;
    r.valid = pos_valid;
    r.dir   = dir;
    r.mov   = moving;
    r.err   = err;
    r.step  = step_cnt;
`ifdef LED_MON_LAP_COUNT_EN
    r.lap   = lap_cnt;
`else
    r.lap   = 8'h00;
`endif
    return r;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("pos=%0d valid=%b dir=%b moving=%b err=%b step=%0d lap=%0d",
                     s.pos, s.valid, s.dir, s.mov, s.err, s.step, s.lap);
  endfunction

  task automatic do_tick(input logic [15:0] led, input logic clr_here);
    int n;
    n = 0;
    led_in = led;
    @(negedge clk);
    while (tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: got tick=%b want 1", tick);
    end else begin
      clr = clr_here;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
    end
    obs = grab();
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    obs = grab();
  endtask

  task automatic apply(input stim_t s);
    case (s.kind)
      2'd0:    do_tick(s.led, 1'b0);
      2'd1:    do_tick(s.led, 1'b1);
      default: pulse_clr();
    endcase
  endtask

  task automatic push(input logic [15:0] led, input logic [1:0] kind, input snap_t e);
    stim_t s;
    s.led  = led;
    s.kind = kind;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic reset_dut();
    rst    = 1'b1;
    clr    = 1'b0;
    led_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int highs;
    rst    = 1'b1;
    led_in = 16'h8000;
    repeat (3) @(negedge clk);
    obs = grab();
    total++;
    if (obs !== mk(0, 0, 0, 0, 0, 0, 0) || tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got %s tick=%b want all zero", fmt(obs), tick);
    end
    rst   = 1'b0;
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (tick === 1'b1) highs++;
    end
    total++;
    if (highs !== 4) begin
      bad++;
      $display("FAIL tick_rate: got %0d tick cycles in 16 want 4", highs);
    end
  endtask

  task automatic test_acquire();
    snap_t e;
    int k;
    reset_dut();
    push(16'h8000, 2'd0, mk(15, 1, 0, 0, 0, 0, 0));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL acquire[%0d]: got %s want %s", k, fmt(obs), fmt(e));
      end
      k++;
    end
  endtask

  task automatic test_inc_wrap();
    snap_t e;
    int k;
    reset_dut();
    push(16'h8000, 2'd0, mk(15, 1, 0, 0, 0, 0, 0));
    push(16'h0001, 2'd0, mk(0, 1, 1, 1, 0, 1, 1));
    push(16'h0002, 2'd0, mk(1, 1, 1, 1, 0, 2, 1));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL inc_wrap[%0d]: got %s want %s", k, fmt(obs), fmt(e));
      end
      k++;
    end
  endtask

  task automatic test_dec_wrap();
    snap_t e;
    int k;
    reset_dut();
    push(16'h0001, 2'd0, mk(0, 1, 0, 0, 0, 0, 0));
    push(16'h8000, 2'd0, mk(15, 1, 0, 1, 0, 1, 1));
    push(16'h4000, 2'd0, mk(14, 1, 0, 1, 0, 2, 1));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL dec_wrap[%0d]: got %s want %s", k, fmt(obs), fmt(e));
      end
      k++;
    end
  endtask

  // Hold after an increment, then a two-position jump, clr and re-acquire.
  task automatic test_hold_and_jump();
    snap_t e;
    int k;
    reset_dut();
    push(16'h0002, 2'd0, mk(1, 1, 0, 0, 0, 0, 0));
    push(16'h0004, 2'd0, mk(2, 1, 1, 1, 0, 1, 0));
    push(16'h0004, 2'd0, mk(2, 1, 1, 0, 0, 1, 0));
    push(16'h0004, 2'd0, mk(2, 1, 1, 0, 0, 1, 0));
    push(16'h0004, 2'd0, mk(2, 1, 1, 0, 0, 1, 0));
    push(16'h0010, 2'd0, mk(2, 0, 1, 0, 1, 1, 0));
    push(16'h0008, 2'd0, mk(2, 0, 1, 0, 1, 1, 0));
    push(16'h0008, 2'd2, mk(2, 0, 1, 0, 0, 0, 0));
    push(16'h0008, 2'd0, mk(3, 1, 1, 0, 0, 0, 0));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL hold_jump[%0d]: got %s want %s", k, fmt(obs), fmt(e));
      end
      k++;
    end
  endtask

  // Blank bus at acquisition, clr colliding with a tick, then a two-bit pattern.
  task automatic test_fault_clr_tick();
    snap_t e;
    int k;
    reset_dut();
    push(16'h0000, 2'd0, mk(0, 0, 0, 0, 1, 0, 0));
    push(16'h0001, 2'd1, mk(0, 0, 0, 0, 0, 0, 0));
    push(16'h0001, 2'd0, mk(0, 1, 0, 0, 0, 0, 0));
    push(16'h0003, 2'd0, mk(0, 0, 0, 0, 1, 0, 0));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL fault_clr[%0d]: got %s want %s", k, fmt(obs), fmt(e));
      end
      k++;
    end
  endtask

  // Long back-to-back rotation: step counter must saturate at 255.
  task automatic test_back_to_back();
    snap_t e;
    logic [15:0] one;
    int k;
    reset_dut();
    one = 16'h0001;
    push(one, 2'd0, mk(0, 1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 260; i++) begin
      push(one << (i % 16), 2'd0, mk(i % 16, 1, 1, 1, 0, (i > 255) ? 255 : i, i / 16));
    end
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %s want %s", k, fmt(obs), fmt(e));
      end
      k++;
    end
  endtask

  // Asynchronous reset in the middle of a clock period while tracking.
  task automatic test_mid_reset();
    snap_t e;
    int k;
    reset_dut();
    push(16'h0001, 2'd0, mk(0, 1, 0, 0, 0, 0, 0));
    push(16'h0002, 2'd0, mk(1, 1, 1, 1, 0, 1, 0));
    k = 0;
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL mid_reset_pre[%0d]: got %s want %s", k, fmt(obs), fmt(e));
      end
      k++;
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    obs = grab();
    total++;
    if (obs !== mk(0, 0, 0, 0, 0, 0, 0) || tick !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got %s tick=%b want all zero", fmt(obs), tick);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_inc_wrap();
    test_dec_wrap();
    test_hold_and_jump();
    test_fault_clr_tick();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/led_rotation_monitor.md
Name: led_rotation_monitor

Overview:
Receive-side checker for the rotating one-hot LED bus produced by the LED rotator block.
- Samples the 16-bit LED vector on a divided tick and encodes the lit position.
- Infers rotation direction and whether the pattern is moving.
- Counts steps and flags illegal patterns: not one-hot, or a jump larger than one position.
- Sits beside the rotator on the board, or in the bench, as a self-check of the rotator output.

Parameters:
WIDTH, 16, LED bus width; must be >= 3
POS_W, 4, position width; must satisfy 2**POS_W >= WIDTH
CNT_W, 8, step counter width (and lap counter width when enabled)
DIV_N, 25, divider width; sample tick once every 2**DIV_N clk cycles

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
clr  in  1  synchronous clear of fault and counters
led_in  in  WIDTH  LED vector under observation
pos  out  POS_W  index of the lit bit
pos_valid  out  1  pos holds a tracked position
dir  out  1  1 = position incrementing (bit WIDTH-1 wraps to 0); 0 = decrementing
moving  out  1  last accepted sample differed from the previous one by one step
err  out  1  sticky fault flag
step_cnt  out  CNT_W  number of accepted one-position steps, saturating
tick  out  1  sample strobe, one clk wide, for debug

Behaviour:
- Divider: DIV_N-bit free-running counter, +1 every clk. tick = (counter == all ones).
- led_in is captured only at a clk edge where tick=1. All outputs are registered and update at that same edge; there is no extra pipeline.
- onehot = exactly one bit of led_in set. idx = index of that bit.
- delta = (idx - pos) mod WIDTH.
- FSM states:
  - ACQ: on tick with onehot -> pos=idx, pos_valid=1, moving=0, go to TRACK. On tick without onehot -> err=1, go to FAULT.
  - TRACK: on tick:
    - not onehot -> FAULT.
    - delta=0 -> moving=0; dir held; step_cnt unchanged.
    - delta=1 -> dir=1, moving=1, pos=idx, step_cnt+1.
    - delta=WIDTH-1 -> dir=0, moving=1, pos=idx, step_cnt+1.
    - any other delta -> FAULT.
  - FAULT: err=1, pos_valid=0, moving=0. pos, dir and step_cnt frozen. Ignores ticks. Leaves only on clr.
- Entering FAULT from any state sets err=1, pos_valid=0, moving=0 at that edge.
- clr (any state): go to ACQ; err=0, pos_valid=0, moving=0, step_cnt=0. pos and dir are held. The divider is not cleared.
- clr has priority over a coincident tick: that sample is discarded.
- step_cnt saturates at 2**CNT_W-1.
- Wrap-around: WIDTH-1 -> 0 is delta=1 (dir=1). 0 -> WIDTH-1 is delta=WIDTH-1 (dir=0).
- Reset mid-operation: everything returns immediately to reset values.
  - Reset values: state ACQ, divider 0, pos=0, pos_valid=0, dir=0, moving=0, err=0, step_cnt=0.
  - tick=0 while the divider is not all ones.

Optional Feature:
Macro LED_MON_LAP_COUNT_EN.
- Defined: adds output lap_cnt [CNT_W-1:0].
  - Increments (saturating) on an accepted step that wraps: WIDTH-1 -> 0 with dir=1, or 0 -> WIDTH-1 with dir=0.
  - Cleared by rst and clr; frozen in FAULT.
- Undefined: no lap_cnt port and no lap logic.

Decomposition:
- Shared package led_mon_pkg holds:
  - state encoding: ACQ=2'd0, TRACK=2'd1, FAULT=2'd2
  - direction constants: DIR_DEC=1'b0, DIR_INC=1'b1
- One sub-module: led_tick_gen (parameter DIV_N; ports clk, rst, tick). Free-running counter plus all-ones compare.
- One-hot check, encoder and FSM stay in the top module.

Test Plan:
(All with DIV_N=2, so tick every 4 clk; WIDTH=16.)
1. rst, then led_in=16'h8000 -> at first tick: pos=15, pos_valid=1, moving=0, err=0, step_cnt=0.
2. Ticks with 16'h8000, 16'h0001, 16'h0002 -> pos=0 then 1; dir=1; moving=1; step_cnt=2; with the macro, lap_cnt=1.
3. Ticks with 16'h0001, 16'h8000, 16'h4000 -> pos=15 then 14; dir=0; step_cnt=2; with the macro, lap_cnt=1.
4. Hold 16'h0004 for 3 ticks after a dir=1 step -> moving=0, dir stays 1, step_cnt unchanged.
5. Sequence 16'h0004 then 16'h0010 -> err=1, pos_valid=0, pos stays 2. Then 16'h0008 changes nothing. Pulse clr -> err=0, step_cnt=0; next tick re-acquires pos=3.
6. led_in=16'h0000 at first tick -> FAULT, err=1. Then clr asserted in the same cycle as a tick with 16'h0001 -> state ACQ, pos_valid=0. Following tick -> pos=0, pos_valid=1.
